// File: rtl/calc_pkg.sv
// calc_pkg: shared codes and state encoding for the calculator sequencer.
// Key, op and display-select encodings match the key decoder and ALU.
package calc_pkg;

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'd0,
        KEY_OP    = 2'd1,
        KEY_EQ    = 2'd2,
        KEY_CLR   = 2'd3
    } key_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_RES = 2'd2,
        SEL_ERR = 2'd3
    } sel_t;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW_RESULT,
        ERROR
    } state_t;

endpackage

// File: rtl/operand_accum.sv
// operand_accum: decimal digit accumulator with clear, load and a
// digit-count limit; digits past DIGITS are dropped.
import calc_pkg::*;

module operand_accum #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [CW-1:0]    load_cnt,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_val;
            count <= load_cnt;
        end else if (push && count < CW'(DIGITS)) begin
            value <= value * WIDTH'(10) + WIDTH'(digit);
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand capture, ALU launch and result display.
// Define CALC_TIMEOUT_EN to add an EXEC watchdog of ALU_TIMEOUT cycles.
import calc_pkg::*;

module calc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 4,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [1:0]       key_type,
    input  logic [3:0]       key_data,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_value,
    output logic [1:0]       disp_sel,
    output logic             busy,
    output logic             new_operation
);

    localparam int CW = $clog2(DIGITS + 1);

    if (ALU_TIMEOUT < 1) begin : g_bad_timeout
        $error("calc_sequencer: ALU_TIMEOUT must be at least 1");
    end

    state_t           state, state_n;
    op_t              pend_op, pend_op_n, next_op, next_op_n;
    logic             chain, chain_n, abort, abort_n;
    logic [WIDTH-1:0] r_val, r_val_n;
    logic             start_n, newop_n;
    logic             a_clr, a_load, a_push, b_clr, b_push;
    logic [WIDTH-1:0] a_ld_val, a_val, b_val;
    logic [CW-1:0]    a_ld_cnt, a_cnt, b_cnt;
    logic             is_dig, is_op, is_eq, is_clr, done_ok, tmo_hit;

    assign is_dig = key_valid && key_type == KEY_DIGIT && key_data <= 4'd9;
    assign is_op  = key_valid && key_type == KEY_OP && key_data <= 4'd3;
    assign is_eq  = key_valid && key_type == KEY_EQ;
    assign is_clr = key_valid && key_type == KEY_CLR;
    // A done in the launch cycle belongs to no request and is ignored.
    assign done_ok = alu_done && state == EXEC && !alu_start && !abort;

`ifdef CALC_TIMEOUT_EN
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != EXEC) tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo_hit = state == EXEC && tmo_cnt == TW'(ALU_TIMEOUT - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    operand_accum #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(CW)) u_acc_a (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load),
        .load_val(a_ld_val), .load_cnt(a_ld_cnt), .push(a_push),
        .digit(key_data), .value(a_val), .count(a_cnt)
    );

    operand_accum #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(CW)) u_acc_b (
        .clk(clk), .rst(rst), .clr(b_clr), .load(1'b0),
        .load_val('0), .load_cnt('0), .push(b_push),
        .digit(key_data), .value(b_val), .count(b_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ENTER_A;
            pend_op       <= OP_ADD;
            next_op       <= OP_ADD;
            chain         <= 1'b0;
            r_val         <= '0;
            alu_start     <= 1'b0;
            new_operation <= 1'b0;
            abort         <= (state == EXEC);
        end else begin
            state         <= state_n;
            pend_op       <= pend_op_n;
            next_op       <= next_op_n;
            chain         <= chain_n;
            r_val         <= r_val_n;
            alu_start     <= start_n;
            new_operation <= newop_n;
            abort         <= abort_n;
        end
    end

    always_comb begin
        state_n   = state;
        pend_op_n = pend_op;
        next_op_n = next_op;
        chain_n   = chain;
        r_val_n   = r_val;
        abort_n   = abort;
        start_n   = 1'b0;
        newop_n   = 1'b0;
        a_clr     = 1'b0;
        a_load    = 1'b0;
        a_push    = 1'b0;
        a_ld_val  = r_val;
        a_ld_cnt  = '0;
        b_clr     = 1'b0;
        b_push    = 1'b0;
        if (abort && alu_done) abort_n = 1'b0;
        if (is_clr) begin
            state_n   = ENTER_A;
            pend_op_n = OP_ADD;
            next_op_n = OP_ADD;
            chain_n   = 1'b0;
            r_val_n   = '0;
            a_clr     = 1'b1;
            b_clr     = 1'b1;
            if (state == EXEC && !done_ok) abort_n = 1'b1;
        end else begin
            unique case (state)
                ENTER_A: begin
                    if (is_dig) begin
                        a_push = 1'b1;
                    end else if (is_op) begin
                        pend_op_n = op_t'(key_data[1:0]);
                        b_clr     = 1'b1;
                        state_n   = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_dig) begin
                        b_push = 1'b1;
                    end else if (is_op && b_cnt == '0) begin
                        pend_op_n = op_t'(key_data[1:0]);
                    end else if (is_op) begin
                        next_op_n = op_t'(key_data[1:0]);
                        chain_n   = 1'b1;
                        start_n   = 1'b1;
                        state_n   = EXEC;
                    end else if (is_eq && b_cnt != '0) begin
                        start_n = 1'b1;
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    if (done_ok && alu_err) begin
                        state_n = ERROR;
                    end else if (done_ok) begin
                        r_val_n = alu_result;
                        if (chain) begin
                            a_load    = 1'b1;
                            a_ld_val  = alu_result;
                            pend_op_n = next_op;
                            b_clr     = 1'b1;
                            chain_n   = 1'b0;
                            state_n   = ENTER_B;
                        end else begin
                            state_n = SHOW_RESULT;
                        end
                    end else if (tmo_hit) begin
                        abort_n = 1'b1;
                        state_n = ERROR;
                    end
                end
                SHOW_RESULT: begin
                    if (is_op) begin
                        a_load    = 1'b1;
                        pend_op_n = op_t'(key_data[1:0]);
                        b_clr     = 1'b1;
                        newop_n   = 1'b1;
                        state_n   = ENTER_B;
                    end else if (is_dig) begin
                        a_load   = 1'b1;
                        a_ld_val = WIDTH'(key_data);
                        a_ld_cnt = CW'(1);
                        state_n  = ENTER_A;
                    end
                end
                ERROR: ;
                default: state_n = ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp_sel   = SEL_A;
        disp_value = a_val;
        unique case (state)
            ENTER_B, EXEC: begin
                disp_sel   = SEL_B;
                disp_value = b_val;
            end
            SHOW_RESULT: begin
                disp_sel   = SEL_RES;
                disp_value = r_val;
            end
            ERROR: begin
                disp_sel   = SEL_ERR;
                disp_value = '0;
            end
            default: ;
        endcase
    end

    assign alu_a  = a_val;
    assign alu_b  = b_val;
    assign alu_op = pend_op;
    assign busy   = (state == EXEC);

    always_ff @(posedge clk) begin
        if (!rst) assert (a_cnt <= CW'(DIGITS) && b_cnt <= CW'(DIGITS));
    end

endmodule
